// File: rtl/iso14443_2a_tx_fdt_encoder_if.sv
// Bit handshake between the frame encoder (master) and the FDT-aligned
// transmit encoder (slave).
interface iso14443_2a_tx_fdt_encoder_if;
  logic tx_data;
  logic tx_data_valid;
  logic tx_last_bit;
  logic tx_req;

  modport master (output tx_data, tx_data_valid, tx_last_bit, input tx_req);
  modport slave  (input tx_data, tx_data_valid, tx_last_bit, output tx_req);
endinterface

// File: rtl/iso14443_2a_tx_fdt_encoder.sv
// PICC-to-PCD transmit encoder: FDT grid alignment, SOC, Manchester data
// bits with subcarrier, EOC, runtime bit-rate selection.
module iso14443_2a_tx_fdt_encoder #(
  parameter int BIT_CLKS_BASE = 128,
  parameter int SC_HALF       = 8,
  parameter int FDT_OFFSET_1  = 84,
  parameter int FDT_OFFSET_0  = 20,
  parameter int FDT_MAX_N     = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fdt_trigger,
  input  logic                               rx_last_bit,
  input  logic [1:0]                         bit_rate_sel,
  iso14443_2a_tx_fdt_encoder_if.slave        tx_bus,
  output logic                               lm_out,
  output logic                               busy,
  output logic                               tx_error
);

  localparam int CW = $clog2(FDT_OFFSET_1 + FDT_MAX_N * BIT_CLKS_BASE + 1);
  localparam int BW = $clog2(BIT_CLKS_BASE);
  localparam int NW = $clog2(FDT_MAX_N + 1);

  typedef enum logic [2:0] {IDLE, ARMED, SOC, DATA, EOC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] fdt_cnt_q, fdt_cnt_d;
  logic [CW-1:0] grid_q, grid_d;
  logic [NW-1:0] fdt_n_q, fdt_n_d;
  logic [1:0]    sel_q, sel_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bit_val_q, bit_val_d;
  logic          last_q, last_d;
  logic          timeout_q, timeout_d;
  logic          lm_d;
  logic          req;
  logic          underrun;

  logic [BW:0]   bit_clks;
  logic [BW:0]   half_clks;
  logic [BW:0]   half_pos;
  logic          bit_end;
  logic          first_half;
  logic          sc_high;

  assign bit_clks  = (BW+1)'(BIT_CLKS_BASE) >> sel_q;
  assign half_clks = bit_clks >> 1;
  assign bit_end   = ({1'b0, bit_cnt_q} == bit_clks - (BW+1)'(1));

  assign tx_bus.tx_req = req;
  assign busy          = (state_q == SOC) || (state_q == DATA) || (state_q == EOC);
  assign tx_error      = timeout_q | underrun;

  // fdt_cnt holds the cycle index relative to the trigger cycle, so a grid
  // hit is decided one cycle early and lm_out (registered) lands on the grid.
  always_comb begin
    state_d    = state_q;
    fdt_cnt_d  = fdt_cnt_q;
    grid_d     = grid_q;
    fdt_n_d    = fdt_n_q;
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    bit_val_d  = bit_val_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    req        = 1'b0;
    underrun   = 1'b0;

    if ((state_q == IDLE || state_q == ARMED) && fdt_trigger) begin
      state_d   = ARMED;
      fdt_cnt_d = CW'(1);
      fdt_n_d   = '0;
      sel_d     = bit_rate_sel;
      grid_d    = rx_last_bit ? CW'(FDT_OFFSET_1) : CW'(FDT_OFFSET_0);
    end else begin
      case (state_q)
        ARMED: begin
          fdt_cnt_d = fdt_cnt_q + CW'(1);
          if (fdt_cnt_q + CW'(1) == grid_q) begin
            if (tx_bus.tx_data_valid) begin
              state_d   = SOC;
              bit_cnt_d = '0;
              bit_val_d = 1'b1;
              last_d    = 1'b0;
            end else if (fdt_n_q == NW'(FDT_MAX_N - 1)) begin
              timeout_d = 1'b1;
              state_d   = IDLE;
            end else begin
              fdt_n_d = fdt_n_q + NW'(1);
              grid_d  = grid_q + CW'(bit_clks);
            end
          end
        end
        SOC, DATA: begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_end) begin
            bit_cnt_d = '0;
            if (last_q) begin
              state_d = EOC;
            end else if (tx_bus.tx_data_valid) begin
              req       = 1'b1;
              state_d   = DATA;
              bit_val_d = tx_bus.tx_data;
              last_d    = tx_bus.tx_last_bit;
            end else begin
              underrun = 1'b1;
              state_d  = EOC;
            end
          end
        end
        EOC: begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_end) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Modulation is computed for the upcoming cycle so lm_out comes straight from a flop.
  always_comb begin
    half_pos   = {1'b0, bit_cnt_d} & (half_clks - (BW+1)'(1));
    first_half = ({1'b0, bit_cnt_d} < half_clks);
    sc_high    = ((half_pos & (BW+1)'(SC_HALF)) == '0);
    lm_d       = 1'b0;
    if (state_d == SOC || state_d == DATA) begin
      lm_d = (bit_val_d ? first_half : !first_half) && sc_high;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fdt_cnt_q <= '0;
      grid_q    <= '0;
      fdt_n_q   <= '0;
      sel_q     <= '0;
      bit_cnt_q <= '0;
      bit_val_q <= 1'b0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      lm_out    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fdt_cnt_q <= fdt_cnt_d;
      grid_q    <= grid_d;
      fdt_n_q   <= fdt_n_d;
      sel_q     <= sel_d;
      bit_cnt_q <= bit_cnt_d;
      bit_val_q <= bit_val_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      lm_out    <= lm_d;
    end
  end

endmodule

// File: tb/tb_iso14443_2a_tx_fdt_encoder.sv
// Directed bench for the FDT-aligned transmit encoder; every cycle of each
// scenario is compared against {lm_out, tx_req, busy, tx_error} expectations.
module tb_iso14443_2a_tx_fdt_encoder;
  localparam int BASE = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fdt_trigger = 1'b0;
  logic       rx_last_bit = 1'b0;
  logic [1:0] bit_rate_sel = 2'd0;
  logic       lm_out;
  logic       busy;
  logic       tx_error;

  int passed = 0;
  int total = 0;

  iso14443_2a_tx_fdt_encoder_if bus ();

  iso14443_2a_tx_fdt_encoder #(
    .BIT_CLKS_BASE(BASE),
    .SC_HALF(8),
    .FDT_OFFSET_1(84),
    .FDT_OFFSET_0(20),
    .FDT_MAX_N(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fdt_trigger(fdt_trigger),
    .rx_last_bit(rx_last_bit),
    .bit_rate_sel(bit_rate_sel),
    .tx_bus(bus),
    .lm_out(lm_out),
    .busy(busy),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] observe();
    return {lm_out, bus.tx_req, busy, tx_error};
  endfunction

  task automatic check(input string tag, input int c, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: observed {lm,req,busy,err}=%b expected %b", tag, c, obs, exp);
  endtask

  // Expected load-modulator level at offset k inside a bit of value b.
  function automatic logic bit_lm(input logic b, input int k, input int bc);
    int  half;
    int  pos;
    logic first;
    half  = bc / 2;
    pos   = k % half;
    first = (k < half);
    return (b ? first : !first) && ((pos / 8) % 2 == 0);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the trigger cycle; start is the hand-computed SOC cycle.
  task automatic run_frame(input string tag, input logic [1:0] sel, input logic rx,
                           input int start, input int valid_from, input logic [7:0] bits,
                           input int ndata, input bit underrun);
    int bc;
    int consumed;
    int stop;
    int p;
    int s;
    int k;
    logic [3:0] exp;
    bc       = BASE >> sel;
    consumed = 0;
    stop     = start + (ndata + 2) * bc + 2;
    for (int c = 0; c <= stop; c++) begin
      next_cycle();
      fdt_trigger       = (c == 0);
      rx_last_bit       = rx;
      bit_rate_sel      = (c == 0) ? sel : ~sel;
      bus.tx_data_valid = (c >= valid_from) && (consumed < ndata);
      bus.tx_data       = (consumed < ndata) ? bits[consumed] : 1'b0;
      bus.tx_last_bit   = !underrun && (consumed == ndata - 1);
      exp = 4'b0000;
      if (c >= start) begin
        p = c - start;
        s = p / bc;
        k = p % bc;
        if (s == 0) exp[3] = bit_lm(1'b1, k, bc);
        else if (s <= ndata) exp[3] = bit_lm(bits[s-1], k, bc);
        exp[2] = (k == bc - 1) && (s < ndata);
        exp[1] = (s <= ndata + 1);
        exp[0] = underrun && (k == bc - 1) && (s == ndata);
      end
      #1;
      check(tag, c, observe(), exp);
      if (exp[2]) consumed++;
    end
    fdt_trigger       = 1'b0;
    bus.tx_data_valid = 1'b0;
    bus.tx_last_bit   = 1'b0;
  endtask

  initial begin
    bus.tx_data       = 1'b0;
    bus.tx_data_valid = 1'b0;
    bus.tx_last_bit   = 1'b0;

    next_cycle();
    next_cycle();
    check("reset_held", 0, observe(), 4'b0000);
    rst_n = 1'b1;
    next_cycle();
    check("reset_released", 0, observe(), 4'b0000);

    run_frame("sel0_rx1_frame10", 2'd0, 1'b1, 84, 0, 8'b0000_0001, 2, 1'b0);
    run_frame("late_valid_n2", 2'd0, 1'b1, 340, 300, 8'b0000_0001, 1, 1'b0);
    run_frame("rx0_offset20", 2'd0, 1'b0, 20, 0, 8'b0000_0010, 2, 1'b0);
    run_frame("underrun", 2'd0, 1'b1, 84, 0, 8'b0000_0101, 1, 1'b1);
    run_frame("sel2_frame", 2'd2, 1'b1, 84, 0, 8'b0000_0110, 3, 1'b0);
    run_frame("sel3_frame", 2'd3, 1'b1, 84, 0, 8'b0000_0101, 4, 1'b0);

    // FDT timeout at sel=2: 64 empty grid slots, last one at 84+63*32.
    for (int c = 0; c <= 2102; c++) begin
      next_cycle();
      fdt_trigger  = (c == 0);
      rx_last_bit  = 1'b1;
      bit_rate_sel = 2'd2;
      #1;
      check("fdt_timeout", c, observe(), (c == 2100) ? 4'b0001 : 4'b0000);
    end
    fdt_trigger = 1'b0;

    bus.tx_data       = 1'b1;
    bus.tx_data_valid = 1'b1;
    bit_rate_sel      = 2'd0;
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      #1;
      check("no_trigger", c, observe(), 4'b0000);
    end

    // Reset while the first DATA bit is modulating (SOC 84..211, k=3 of bit 1).
    for (int c = 0; c <= 215; c++) begin
      next_cycle();
      fdt_trigger = (c == 0);
      rx_last_bit = 1'b1;
    end
    #1;
    check("mid_data_before_reset", 215, observe(), 4'b1010);
    rst_n = 1'b0;
    #1;
    check("async_reset_lm", 215, observe(), 4'b0000);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      #1;
      check("after_reset_quiet", c, observe(), 4'b0000);
    end
    bus.tx_data_valid = 1'b0;

    run_frame("after_reset_rx0", 2'd0, 1'b0, 20, 0, 8'b0000_0000, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iso14443_2a_tx_fdt_encoder.md
# iso14443_2a_tx_fdt_encoder

PICC-to-PCD transmit encoder with frame-delay-time (FDT) alignment and runtime-selectable bit rate. It takes a bit stream over a request/valid handshake and emits an SOC, Manchester-with-subcarrier data bits and an EOC. The first modulation is placed on the FDT grid measured from the end of the last PCD pause. It sits between the frame encoder and the load modulator, replacing the fixed 106 kbit/s bit encoder.

## Interface
- BIT_CLKS_BASE, 128, clocks per bit at bit_rate_sel=0 (power of two)
- SC_HALF, 8, subcarrier half-period in clocks (fc/16)
- FDT_OFFSET_1, 84, grid offset when last PCD bit was '1'
- FDT_OFFSET_0, 20, grid offset when last PCD bit was '0'
- FDT_MAX_N, 64, grid slots searched before giving up
- clk  in  1  carrier-derived clock
- rst_n  in  1  reset; one clock, reset asynchronous active-low
- fdt_trigger  in  1  one-cycle pulse: last PCD pause ended
- rx_last_bit  in  1  value of last PCD bit, sampled with fdt_trigger
- bit_rate_sel  in  2  BIT_CLKS = BIT_CLKS_BASE >> sel, sampled at frame start
- tx_data  in  1  bit to send
- tx_data_valid  in  1  tx_data/tx_last_bit valid; held until consumed
- tx_last_bit  in  1  current bit is final bit of frame
- tx_req  out  1  one-cycle pulse: presented bit consumed
- lm_out  out  1  load modulator drive (registered)
- busy  out  1  high from SOC start to end of EOC
- tx_error  out  1  one-cycle pulse: underrun or FDT timeout

## Operation
- States: IDLE, ARMED, SOC, DATA, EOC.
- IDLE: a fdt_trigger pulse latches rx_last_bit, clears fdt_cnt and fdt_n, then goes to ARMED. With no trigger the encoder never transmits, even if tx_data_valid=1.
- ARMED: fdt_cnt counts clocks since the trigger cycle (cycle 0).
  - Grid points are at cycles OFFSET + n*BIT_CLKS, where OFFSET is FDT_OFFSET_1 or FDT_OFFSET_0 per the latched rx_last_bit. BIT_CLKS is taken from bit_rate_sel as sampled at the trigger.
  - At a grid point with tx_data_valid=1, go to SOC.
  - At a grid point without valid, increment fdt_n. When fdt_n reaches FDT_MAX_N, pulse tx_error and return to IDLE.
  - A new fdt_trigger in ARMED restarts the count.
- Manchester encoding, each bit = two halves of BIT_CLKS/2:
  - '1' modulates the first half and leaves the second half unmodulated.
  - '0' leaves the first half unmodulated and modulates the second half.
  - In a modulated half, lm_out = subcarrier. The subcarrier phase restarts at each half: high for SC_HALF clocks, then low for SC_HALF, repeating.
- SOC: one '1' bit.
- Bit consumption: on the last clock of SOC, and of each DATA bit, the encoder pulses tx_req with tx_data_valid=1 and latches tx_data/tx_last_bit. The next cycle starts a DATA bit.
- After a bit with tx_last_bit=1, no bit is consumed. The encoder goes to EOC, which is one unmodulated bit period, then to IDLE. The FDT is disarmed; each frame needs a new trigger.
- Underrun: if tx_data_valid=0 on a consume clock, pulse tx_error and go to EOC.
- fdt_trigger is ignored in SOC, DATA and EOC.
- bit_rate_sel changes mid-frame are ignored.

## Timing
- Reset values: lm_out=0, tx_req=0, busy=0, tx_error=0, state IDLE. Reset mid-frame forces lm_out=0 asynchronously.
- First lm_out=1 cycle = trigger cycle + OFFSET + n*BIT_CLKS. busy rises the same cycle.
- SOC lasts exactly BIT_CLKS cycles. Each DATA bit lasts BIT_CLKS cycles. There is no gap between bits.
- tx_req is high on the last cycle of SOC and of each DATA bit, i.e. every BIT_CLKS cycles.
- EOC lasts BIT_CLKS cycles with lm_out=0. busy falls after the last EOC cycle.
- Earliest next trigger acceptance: the first cycle back in IDLE.
- Counters are sized for (FDT_OFFSET_1 + FDT_MAX_N*BIT_CLKS_BASE) without wrap.
- bit_rate_sel=3 gives BIT_CLKS=16: each half-bit is exactly one SC_HALF.

## Test plan
- sel=0, rx_last_bit=1, tx_data_valid set before the trigger, frame '1','0' (last):
  - first lm_out=1 at cycle 84;
  - SOC pattern 8 high / 8 low ×4, then 64 low;
  - tx_req at cycles 211 and 339;
  - EOC cycles 468–595; busy low at 596.
- Valid asserted at cycle 300 (rx_last_bit=1) -> SOC starts at cycle 340 (n=2).
- rx_last_bit=0 -> SOC at cycle 20. With no trigger ever -> lm_out stays 0 for 10000 cycles.
- Valid dropped after the first bit of a 3-bit frame -> tx_error pulse on the second consume clock, then one unmodulated EOC bit and IDLE.
- sel=2 (BIT_CLKS=32), rx_last_bit=1 -> start at 84, tx_req every 32 cycles. Never valid -> tx_error at cycle 84+63*32 = 2100.
- Reset asserted mid-DATA -> lm_out=0 immediately. After release, no output until the next trigger.
